fetcher: RTL and testbench
==========================

Name: fetcher

Overview:
- Front-end stage sitting directly upstream of the decoder.
- Drives the PC and issues one instruction request at a time to the instruction cache.
- Pre-decodes each returned instruction for static/dynamic branch prediction using a 2-bit-counter BHT.
- Buffers {inst, pc, predict} in an instruction queue whose head feeds the decoder; ROB redirects flush the queue and restart fetch.

Parameters:
- IQ_DEPTH, 8: instruction queue entries; power of two, at least 2.
- BHT_ENTRIES, 256: number of 2-bit counters; power of two.
- RESET_PC, 32'h0: PC loaded at reset.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous and active-high.
- rdy  in  1  global run enable; when low, all state holds and all inputs are ignored.
- out_icache_req  out  1  request strobe, one cycle per request.
- out_icache_addr  out  32  request address; valid with the strobe.
- in_icache_valid  in  1  response valid, one cycle.
- in_icache_inst  in  32  returned instruction.
- in_stall  in  1  downstream (RS/LSB/ROB) cannot accept this cycle.
- out_inst_valid  out  1  IQ head valid.
- out_inst  out  32  IQ head instruction.
- out_pc  out  32  IQ head PC.
- out_predict  out  1  IQ head predicted-taken flag.
- in_rob_redirect  in  1  mispredict flush.
- in_rob_redirect_pc  in  32  correct PC after a flush.
- in_rob_branch_commit  in  1  conditional branch committed.
- in_rob_branch_pc  in  32  PC of the committed branch.
- in_rob_branch_taken  in  1  actual outcome of the committed branch.

Behaviour:
- Reset values:
  - pc = RESET_PC; state = IDLE; IQ empty (head = tail = count = 0).
  - All outputs 0.
  - All BHT counters = 2'b01 (weakly not taken).
- States:
  - IDLE: issue is allowed.
  - WAIT: one request outstanding.
  - DISCARD: one outstanding request whose response must be dropped.
- IDLE -> WAIT:
  - Taken when count + 1 <= IQ_DEPTH after accounting for a same-cycle pop, and there is no redirect.
  - Drive out_icache_req = 1 and out_icache_addr = pc for exactly that cycle.
- WAIT -> IDLE on in_icache_valid. The instruction is pre-decoded by opcode [6:0]:
  - JAL (1101111): next_pc = pc + sign-extended J-immediate; predict = 1.
  - BRANCH (1100011): index = pc[log2(BHT_ENTRIES)+1:2]. If counter[1] = 1, next_pc = pc + sign-extended B-immediate and predict = 1; otherwise next_pc = pc + 4 and predict = 0.
  - All other opcodes, including JALR: next_pc = pc + 4; predict = 0.
  - Push {inst, pc, predict} at the tail; pc <= next_pc. Arithmetic is 32-bit and wraps modulo 2^32.
- Decoder handshake:
  - out_* reflect the IQ head combinationally; out_inst_valid = (count != 0).
  - Pop occurs when out_inst_valid & !in_stall & rdy.
  - Push and pop in the same cycle leave count unchanged. Pointers wrap modulo IQ_DEPTH.
- Redirect (in_rob_redirect & rdy) has the highest priority:
  - IQ cleared; pc <= in_rob_redirect_pc.
  - No pop is reported that cycle; out_inst_valid = 0 next cycle.
  - State WAIT -> DISCARD; IDLE stays IDLE; DISCARD stays DISCARD.
  - A response arriving in the same cycle as the redirect is dropped, and the state goes to IDLE.
  - No new request is issued in the redirect cycle.
- DISCARD -> IDLE on in_icache_valid; the response is not pushed and pc is unchanged.
- BHT update on in_rob_branch_commit & rdy:
  - Counter at index in_rob_branch_pc[log2(BHT_ENTRIES)+1:2] increments if taken, decrements otherwise.
  - Saturates at 2'b11 and 2'b00.
  - A same-cycle lookup of the same index sees the old value.
  - Updates are applied even during a redirect.
- Full IQ: no request is issued. Because at most one request is outstanding and issue is gated, a response never finds the IQ full.
- Asynchronous reset mid-operation returns everything to the reset values immediately. The icache shares rst, so no stale response can arrive.

Test Plan:
- Reset with RESET_PC = 0, then release; icache answers 3 cycles after each request -> requests go to 0x0, 0x4, 0x8 with no overlap; IQ head = inst@0x0, out_predict = 0.
- Response 0x0080006F (jal x0, 8) at pc 0x10 -> next request addr = 0x18; queued entry has predict = 1.
- 0x00000463 (beq +8) at 0x20 with a fresh BHT -> next addr 0x24, predict 0. Then send 2 commits of pc 0x20 taken and refetch 0x20 -> next addr 0x28, predict 1. Then 4 not-taken commits -> counter = 00 (saturation checked).
- Hold in_stall = 1 with IQ_DEPTH = 8 -> exactly 8 entries queued and no 9th request. Release the stall -> pops in order and issue resumes.
- Redirect to 0x100 while a request to 0x40 is outstanding -> 0x40 response dropped, IQ empty, next request addr = 0x100.
- Assert rst while in WAIT with 5 entries queued -> out_inst_valid = 0 immediately; first request after release goes to RESET_PC.

Source files
------------

// File: rtl/fetcher.sv
// Fetch stage: drives the PC, keeps one icache request in flight, pre-decodes
// returned instructions against a 2-bit BHT and queues them for the decoder.
module fetcher #(
  parameter int unsigned IQ_DEPTH    = 8,
  parameter int unsigned BHT_ENTRIES = 256,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        out_icache_req,
  output logic [31:0] out_icache_addr,
  input  logic        in_icache_valid,
  input  logic [31:0] in_icache_inst,
  input  logic        in_stall,
  output logic        out_inst_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        out_predict,
  input  logic        in_rob_redirect,
  input  logic [31:0] in_rob_redirect_pc,
  input  logic        in_rob_branch_commit,
  input  logic [31:0] in_rob_branch_pc,
  input  logic        in_rob_branch_taken
);

  localparam int unsigned PW = $clog2(IQ_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned BW = $clog2(BHT_ENTRIES);
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } state_e;

  state_e        state_q;
  logic [31:0]   pc_q;
  logic [31:0]   pc_d;
  logic          pred_d;
  logic          req_q;
  logic [31:0]   addr_q;

  logic [31:0]   iq_inst_q [IQ_DEPTH];
  logic [31:0]   iq_pc_q   [IQ_DEPTH];
  logic          iq_pred_q [IQ_DEPTH];
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  logic [1:0]    bht_q [BHT_ENTRIES];
  logic [BW-1:0] rd_idx;
  logic [BW-1:0] upd_idx;
  logic [1:0]    rd_ctr;

  logic          redirect;
  logic          pop;
  logic          push;
  logic          issue;
  logic [31:0]   j_imm;
  logic [31:0]   b_imm;
  logic          unused_ok;

  assign unused_ok = ^{in_rob_branch_pc[31:BW+2], in_rob_branch_pc[1:0]};

  assign out_icache_req  = req_q;
  assign out_icache_addr = addr_q;
  assign out_inst_valid  = (count_q != '0);
  assign out_inst        = iq_inst_q[head_q];
  assign out_pc          = iq_pc_q[head_q];
  assign out_predict     = iq_pred_q[head_q];

  assign redirect = rdy & in_rob_redirect;
  assign pop      = rdy & out_inst_valid & ~in_stall & ~in_rob_redirect;
  assign push     = rdy & in_icache_valid & (state_q == ST_WAIT) & ~in_rob_redirect;
  // A same-cycle pop frees a slot, so a full queue may still issue.
  assign issue    = (state_q == ST_IDLE) & ~in_rob_redirect &
                    ((count_q < CW'(IQ_DEPTH)) | pop);
  assign count_d  = count_q + CW'(push) - CW'(pop);

  assign rd_idx  = pc_q[BW+1:2];
  assign upd_idx = in_rob_branch_pc[BW+1:2];
  assign rd_ctr  = bht_q[rd_idx];

  assign j_imm = {{11{in_icache_inst[31]}}, in_icache_inst[31], in_icache_inst[19:12],
                  in_icache_inst[20], in_icache_inst[30:21], 1'b0};
  assign b_imm = {{19{in_icache_inst[31]}}, in_icache_inst[31], in_icache_inst[7],
                  in_icache_inst[30:25], in_icache_inst[11:8], 1'b0};

  // Pre-decode: next fetch PC and predicted-taken flag for the returned word.
  always_comb begin
    pc_d   = pc_q + 32'd4;
    pred_d = 1'b0;
    if (in_icache_inst[6:0] == OP_JAL) begin
      pc_d   = pc_q + j_imm;
      pred_d = 1'b1;
    end else if ((in_icache_inst[6:0] == OP_BRANCH) && rd_ctr[1]) begin
      pc_d   = pc_q + b_imm;
      pred_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      addr_q  <= '0;
    end else if (rdy) begin
      req_q <= 1'b0;
      if (redirect) begin
        pc_q <= in_rob_redirect_pc;
        if (state_q != ST_IDLE) begin
          state_q <= in_icache_valid ? ST_IDLE : ST_DISCARD;
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (issue) begin
              state_q <= ST_WAIT;
              req_q   <= 1'b1;
              addr_q  <= pc_q;
            end
          end
          ST_WAIT: begin
            if (in_icache_valid) begin
              state_q <= ST_IDLE;
              pc_q    <= pc_d;
            end
          end
          ST_DISCARD: begin
            if (in_icache_valid) state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end else begin
      req_q <= 1'b0;
    end
  end

  // Instruction queue: circular buffer, flushed by a redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(IQ_DEPTH); i++) begin
        iq_inst_q[i] <= '0;
        iq_pc_q[i]   <= '0;
        iq_pred_q[i] <= 1'b0;
      end
    end else if (redirect) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        iq_inst_q[tail_q] <= in_icache_inst;
        iq_pc_q[tail_q]   <= pc_q;
        iq_pred_q[tail_q] <= pred_d;
        tail_q            <= tail_q + PW'(1);
      end
      if (pop) head_q <= head_q + PW'(1);
      count_q <= count_d;
    end
  end

  // Saturating 2-bit counters trained by committed branches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(BHT_ENTRIES); i++) bht_q[i] <= 2'b01;
    end else if (rdy && in_rob_branch_commit) begin
      if (in_rob_branch_taken) begin
        if (bht_q[upd_idx] != 2'b11) bht_q[upd_idx] <= bht_q[upd_idx] + 2'b01;
      end else begin
        if (bht_q[upd_idx] != 2'b00) bht_q[upd_idx] <= bht_q[upd_idx] - 2'b01;
      end
    end
  end

endmodule

// File: tb/tb_fetcher.sv
// Bench for fetcher: icache responder, queue/BHT reference model, directed
// pre-decode table and randomized traffic.
module tb_fetcher;

  localparam int          IQD = 8;
  localparam logic [31:0] RPC = 32'h0;
  localparam int          K_OTHER = 0;
  localparam int          K_JAL   = 1;
  localparam int          K_BR    = 2;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        out_icache_req;
  logic [31:0] out_icache_addr;
  logic        in_icache_valid;
  logic [31:0] in_icache_inst;
  logic        in_stall;
  logic        out_inst_valid;
  logic [31:0] out_inst, out_pc;
  logic        out_predict;
  logic        in_rob_redirect;
  logic [31:0] in_rob_redirect_pc;
  logic        in_rob_branch_commit;
  logic [31:0] in_rob_branch_pc;
  logic        in_rob_branch_taken;

  fetcher #(.IQ_DEPTH(IQD), .BHT_ENTRIES(256), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .out_icache_req(out_icache_req), .out_icache_addr(out_icache_addr),
    .in_icache_valid(in_icache_valid), .in_icache_inst(in_icache_inst),
    .in_stall(in_stall),
    .out_inst_valid(out_inst_valid), .out_inst(out_inst), .out_pc(out_pc),
    .out_predict(out_predict),
    .in_rob_redirect(in_rob_redirect), .in_rob_redirect_pc(in_rob_redirect_pc),
    .in_rob_branch_commit(in_rob_branch_commit), .in_rob_branch_pc(in_rob_branch_pc),
    .in_rob_branch_taken(in_rob_branch_taken)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] inst; int kind; int imm; } mrec_t;
  typedef struct { logic [31:0] inst; logic [31:0] pc; logic pred; } ent_t;
  typedef struct {
    logic [31:0] pc; int kind; int imm; int train; logic [31:0] exp_next; logic exp_pred;
  } vec_t;

  mrec_t       pmem [logic [31:0]];
  ent_t        mq[$];
  logic [31:0] mpc;
  bit          m_out, m_disc, exp_req;
  logic [31:0] exp_addr;
  int          bht [256];
  bit          pend;
  int          rcnt, lat, nreq;
  logic [31:0] raddr, last_addr;
  int          checks, failures;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_jal(input int imm);
    logic [31:0] u;
    u = 32'(imm);
    return {u[20], u[10:1], u[11], u[19:12], 5'd0, 7'h6F};
  endfunction

  function automatic logic [31:0] enc_br(input int imm);
    logic [31:0] u;
    u = 32'(imm);
    return {u[12], u[10:5], 5'd0, 5'd0, 3'd0, u[4:1], u[11], 7'h63};
  endfunction

  function automatic mrec_t mk(input int kind, input int imm);
    mrec_t m;
    m.kind = kind;
    m.imm  = imm;
    if (kind == K_JAL)     m.inst = enc_jal(imm);
    else if (kind == K_BR) m.inst = enc_br(imm);
    else                   m.inst = 32'h000080E7;
    return m;
  endfunction

  // Program memory: directed words first, otherwise a hash-generated mix.
  function automatic mrec_t mem(input logic [31:0] addr);
    logic [31:0] h;
    int off;
    mrec_t m;
    if (pmem.exists(addr)) return pmem[addr];
    h   = addr * 32'h9E3779B1;
    off = (int'(h[27:24]) + 1) * 4;
    if (h[23]) off = -off;
    case (h[31:29])
      3'd0:      m = mk(K_JAL, off);
      3'd1, 3'd2: m = mk(K_BR, off);
      3'd3:      m = '{ {h[31:20], 5'd1, 3'd0, 5'd1, 7'h67}, K_OTHER, 0 };
      default:   m = '{ {h[31:15], 3'd0, 5'd1, 7'h13}, K_OTHER, 0 };
    endcase
    return m;
  endfunction

  task automatic model_reset();
    mq.delete();
    mpc = RPC; m_out = 0; m_disc = 0; pend = 0; rcnt = 0;
    for (int i = 0; i < 256; i++) bht[i] = 1;
  endtask

  // One clock: drive inputs, advance the model, compare, then act as icache.
  task automatic step(input bit r, input bit st, input bit rd, input logic [31:0] rpc,
                      input bit cm, input logic [31:0] bpc, input bit tk);
    bit v, pop, pr;
    int idx, bi;
    logic [31:0] nxt;
    mrec_t m;
    ent_t e;
    v = 0;
    if (r && pend) begin
      if (rcnt == 0) begin v = 1; pend = 0; end
      else rcnt--;
    end
    m = mem(raddr);
    rdy = r; in_stall = st; in_rob_redirect = rd; in_rob_redirect_pc = rpc;
    in_rob_branch_commit = cm; in_rob_branch_pc = bpc; in_rob_branch_taken = tk;
    in_icache_valid = v; in_icache_inst = v ? m.inst : 32'h0;

    exp_req = 0;
    if (r) begin
      pop = (mq.size() > 0) && !st && !rd;
      if (rd) begin
        mq.delete();
        mpc = rpc;
        if (v) begin m_out = 0; m_disc = 0; end
        else if (m_out) m_disc = 1;
      end else if (v && m_out) begin
        if (pop) void'(mq.pop_front());
        if (!m_disc) begin
          idx = int'((mpc >> 2) & 32'hFF);
          nxt = mpc + 32'd4; pr = 0;
          if (m.kind == K_JAL) begin nxt = mpc + 32'(m.imm); pr = 1; end
          else if (m.kind == K_BR && bht[idx] >= 2) begin nxt = mpc + 32'(m.imm); pr = 1; end
          e = '{m.inst, mpc, pr};
          mq.push_back(e);
          mpc = nxt;
        end
        m_out = 0; m_disc = 0;
      end else begin
        if (!m_out && (int'(mq.size()) - int'(pop)) < IQD) begin
          exp_req = 1; exp_addr = mpc; m_out = 1;
        end
        if (pop) void'(mq.pop_front());
      end
      if (cm) begin
        bi = int'((bpc >> 2) & 32'hFF);
        if (tk) bht[bi] = (bht[bi] == 3) ? 3 : bht[bi] + 1;
        else    bht[bi] = (bht[bi] == 0) ? 0 : bht[bi] - 1;
      end
    end

    @(posedge clk);
    #1;
    chk("req", 32'(out_icache_req), 32'(exp_req));
    if (exp_req) chk("req_addr", out_icache_addr, exp_addr);
    chk("inst_valid", 32'(out_inst_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("head_inst", out_inst, mq[0].inst);
      chk("head_pc", out_pc, mq[0].pc);
      chk("head_pred", 32'(out_predict), 32'(mq[0].pred));
    end
    if (out_icache_req) begin
      chk("no_overlap", 32'(pend), 32'h0);
      pend = 1; rcnt = lat - 1; raddr = out_icache_addr;
      nreq++; last_addr = out_icache_addr;
    end
    @(negedge clk);
  endtask

  task automatic next_req(input bit st, output logic [31:0] a);
    int n0;
    n0 = nreq;
    for (int i = 0; i < 200 && nreq == n0; i++) step(1, st, 0, 0, 0, 0, 0);
    chk("req_seen", 32'(nreq != n0), 32'h1);
    a = last_addr;
  endtask

  vec_t        vt [11];
  logic [31:0] a;
  int          n0;

  initial begin
    checks = 0; failures = 0; nreq = 0; lat = 3; raddr = 0; last_addr = 0;
    vt[0]  = '{32'h10,       K_JAL,   8,  0, 32'h18, 1'b1};
    vt[1]  = '{32'h20,       K_BR,    8,  0, 32'h24, 1'b0};
    vt[2]  = '{32'h20,       K_BR,    8,  2, 32'h28, 1'b1};
    vt[3]  = '{32'h20,       K_BR,    8, -4, 32'h24, 1'b0};
    vt[4]  = '{32'h20,       K_BR,    8,  1, 32'h24, 1'b0};
    vt[5]  = '{32'h20,       K_BR,    8,  1, 32'h28, 1'b1};
    vt[6]  = '{32'h40,       K_JAL, -16,  0, 32'h30, 1'b1};
    vt[7]  = '{32'h50,       K_OTHER, 0,  0, 32'h54, 1'b0};
    vt[8]  = '{32'h104,      K_BR,   -8,  0, 32'h108, 1'b0};
    vt[9]  = '{32'h200,      K_BR,   -8,  2, 32'h1F8, 1'b1};
    vt[10] = '{32'hFFFFFFFC, K_JAL,   8,  0, 32'h4,  1'b1};
    for (int i = 0; i < 8; i++) pmem[32'(i * 4)] = '{32'h00100093 + 32'(i << 20), K_OTHER, 0};

    rst = 1; rdy = 0; in_icache_valid = 0; in_icache_inst = 0; in_stall = 0;
    in_rob_redirect = 0; in_rob_redirect_pc = 0; in_rob_branch_commit = 0;
    in_rob_branch_pc = 0; in_rob_branch_taken = 0;
    model_reset();
    #1;
    chk("rst_req", 32'(out_icache_req), 32'h0);
    chk("rst_addr", out_icache_addr, 32'h0);
    chk("rst_valid", 32'(out_inst_valid), 32'h0);
    chk("rst_inst", out_inst, 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_pred", 32'(out_predict), 32'h0);
    @(negedge clk); @(negedge clk);
    rst = 0;

    // Sequential fetch from reset with a 3-cycle icache.
    next_req(1, a); chk("seq0", a, 32'h0);
    next_req(1, a); chk("seq1", a, 32'h4);
    next_req(1, a); chk("seq2", a, 32'h8);
    chk("seq_head_pc", out_pc, 32'h0);
    chk("seq_head_inst", out_inst, 32'h00100093);
    chk("seq_head_pred", 32'(out_predict), 32'h0);

    // Pre-decode vectors, optionally after training the BHT.
    for (int i = 0; i < 11; i++) begin
      pmem[vt[i].pc] = mk(vt[i].kind, vt[i].imm);
      for (int k = 0; k < (vt[i].train < 0 ? -vt[i].train : vt[i].train); k++)
        step(1, 1, 0, 0, 1, vt[i].pc, vt[i].train > 0);
      step(1, 1, 1, vt[i].pc, 0, 0, 0);
      next_req(1, a); chk("vec_first", a, vt[i].pc);
      next_req(1, a); chk("vec_next", a, vt[i].exp_next);
      chk("vec_pc", out_pc, vt[i].pc);
      chk("vec_pred", 32'(out_predict), 32'(vt[i].exp_pred));
    end

    // Full queue under stall, then drain.
    step(1, 1, 1, 32'h1000, 0, 0, 0);
    n0 = nreq;
    for (int i = 0; i < 60; i++) step(1, 1, 0, 0, 0, 0, 0);
    chk("full_reqs", 32'(nreq - n0), 32'd8);
    chk("full_valid", 32'(out_inst_valid), 32'h1);
    for (int i = 0; i < 30; i++) step(1, 0, 0, 0, 0, 0, 0);
    chk("resume", 32'(nreq - n0 > 8), 32'h1);

    // Redirect while a request is outstanding.
    lat = 6;
    step(1, 1, 1, 32'h40, 0, 0, 0);
    next_req(1, a); chk("rd_first", a, 32'h40);
    step(1, 1, 1, 32'h100, 0, 0, 0);
    chk("rd_empty", 32'(out_inst_valid), 32'h0);
    next_req(1, a); chk("rd_addr", a, 32'h100);
    chk("rd_dropped", 32'(out_inst_valid), 32'h0);
    lat = 3;

    // Asynchronous reset with five entries queued and a request in flight.
    step(1, 1, 1, 32'h2000, 0, 0, 0);
    for (int i = 0; i < 100 && !(mq.size() == 5 && pend); i++) step(1, 1, 0, 0, 0, 0, 0);
    chk("pre_rst_valid", 32'(out_inst_valid), 32'h1);
    #2 rst = 1;
    #1;
    chk("async_valid", 32'(out_inst_valid), 32'h0);
    chk("async_req", 32'(out_icache_req), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 0;
    next_req(0, a); chk("post_rst_pc", a, RPC);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      lat = int'($urandom_range(1, 4));
      step($urandom_range(0, 9) != 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 39) == 0, 32'($urandom_range(0, 255)) << 2,
           $urandom_range(0, 4) == 0, 32'($urandom_range(0, 255)) << 2,
           1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
